// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, slow-unit results are FIFO-buffered,
// a destination scoreboard exposes RAW hazards, and a starvation counter forces slow writes through.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_addr,
  input  logic [31:0] cpu_data,
  output logic        cpu_stall,
  input  logic        sl_valid,
  output logic        sl_ready,
  input  logic [4:0]  sl_addr,
  input  logic [31:0] sl_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_ready,
  input  logic [4:0]  chk_addr1,
  output logic        chk_busy1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy2,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]    fifo_addr [DEPTH];
  logic [DW-1:0]    fifo_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;

  logic          fifo_empty;
  logic          fifo_full;
  logic          force_fifo;
  logic          grant_cpu;
  logic          grant_fifo;
  logic          push;
  logic          pop;
  logic          iss_acc;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign force_fifo = (starve_cnt == STV_W'(STARVE_LIMIT)) && !fifo_empty;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Port grant: forced slow write, then core, then FIFO head; nothing while in reset.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_fifo = 1'b0;
    if (reset_n) begin
      if (force_fifo)       grant_fifo = 1'b1;
      else if (cpu_we)      grant_cpu  = 1'b1;
      else if (!fifo_empty) grant_fifo = 1'b1;
    end
  end

  always_comb begin
    rf_addr  = '0;
    rf_wdata = '0;
    if (grant_fifo) begin
      rf_addr  = head_addr;
      rf_wdata = head_data;
    end else if (grant_cpu) begin
      rf_addr  = cpu_addr;
      rf_wdata = cpu_data;
    end
  end

  // r0 is hardwired: writes to it are dropped, but a FIFO head still retires.
  assign rf_we     = (grant_cpu || grant_fifo) && (rf_addr != '0);
  assign cpu_stall = reset_n && force_fifo && cpu_we;
  assign sl_ready  = reset_n && !fifo_full;
  assign iss_ready = reset_n && !busy[iss_addr];
  assign chk_busy1 = busy[chk_addr1];
  assign chk_busy2 = busy[chk_addr2];

  assign push    = sl_valid && sl_ready;
  assign pop     = grant_fifo;
  assign iss_acc = iss_valid && iss_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= sl_addr;
      fifo_data[wr_ptr] <= sl_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Counts consecutive cycles a waiting FIFO head is passed over; saturates at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || grant_fifo) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Retiring head clears its destination; a same-edge issue to that register re-sets it.
  always_comb begin
    busy_nxt = busy;
    if (pop)     busy_nxt[head_addr] = 1'b0;
    if (iss_acc) busy_nxt[iss_addr]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed checks plus a queue of expected
// register-file writes that a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic        clk;
  logic        reset_n;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_stall;
  logic        sl_valid;
  logic        sl_ready;
  logic [4:0]  sl_addr;
  logic [31:0] sl_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [4:0]  chk_addr1;
  logic        chk_busy1;
  logic [4:0]  chk_addr2;
  logic        chk_busy2;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;

  int  n_tests = 0;
  int  n_fail  = 0;
  wb_t exp_q[$];

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_stall (cpu_stall),
    .sl_valid  (sl_valid),
    .sl_ready  (sl_ready),
    .sl_addr   (sl_addr),
    .sl_data   (sl_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .chk_addr1 (chk_addr1),
    .chk_busy1 (chk_busy1),
    .chk_addr2 (chk_addr2),
    .chk_busy2 (chk_busy2),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_data  = '0;
    sl_valid  = 1'b0;
    sl_addr   = '0;
    sl_data   = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Each queued expectation is for the cycle in which it was pushed.
  always @(negedge clk) begin
    wb_t e;
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(rf_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wb_addr", 32'(rf_addr), 32'(e.addr));
        check_eq("wb_data", rf_wdata, e.data);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("wb_missing", 32'(rf_we), 32'd1);
    end
  end

  initial begin
    logic stall_exp;
    reset_n   = 1'b0;
    idle();
    chk_addr1 = '0;
    chk_addr2 = '0;
    cpu_we    = 1'b1;
    cpu_addr  = 5'd5;
    iss_addr  = 5'd4;

    // Reset state, with a core request held to show the port is released.
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check_eq("rst_sl_ready", 32'(sl_ready), 32'd0);
    check_eq("rst_iss_ready", 32'(iss_ready), 32'd0);
    check_eq("rst_chk_busy1", 32'(chk_busy1), 32'd0);
    tick();
    reset_n = 1'b1;
    idle();
    @(negedge clk);
    check_eq("post_rst_sl_ready", 32'(sl_ready), 32'd1);
    check_eq("post_rst_iss_ready", 32'(iss_ready), 32'd1);
    tick();

    // Core write lands same cycle.
    cpu_we = 1'b1; cpu_addr = 5'd5; cpu_data = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("cpu_wr_stall", 32'(cpu_stall), 32'd0);
    tick();
    idle();

    // Issue r7, slow result returns, busy clears after the head retires.
    iss_valid = 1'b1; iss_addr = 5'd7;
    @(negedge clk);
    check_eq("iss7_ready", 32'(iss_ready), 32'd1);
    tick();
    idle();
    chk_addr1 = 5'd7;
    sl_valid = 1'b1; sl_addr = 5'd7; sl_data = 32'h1234_5678;
    @(negedge clk);
    check_eq("busy7_set", 32'(chk_busy1), 32'd1);
    check_eq("sl7_ready", 32'(sl_ready), 32'd1);
    tick();
    idle();
    expect_wr(5'd7, 32'h1234_5678);
    @(negedge clk);
    check_eq("busy7_during_pop", 32'(chk_busy1), 32'd1);
    tick();
    @(negedge clk);
    check_eq("busy7_cleared", 32'(chk_busy1), 32'd0);
    tick();

    // Starvation: two buffered results behind a continuously writing core.
    cpu_we = 1'b1; cpu_addr = 5'd20; cpu_data = 32'h100;
    sl_valid = 1'b1; sl_addr = 5'd11; sl_data = 32'hAAAA_0001;
    expect_wr(5'd20, 32'h100);
    @(negedge clk);
    check_eq("starve_k0_stall", 32'(cpu_stall), 32'd0);
    tick();
    for (int i = 1; i <= 11; i++) begin
      cpu_we   = 1'b1;
      cpu_addr = 5'd20;
      cpu_data = 32'h100 + 32'(i);
      sl_valid = (i == 1);
      sl_addr  = 5'd12;
      sl_data  = 32'hBBBB_0002;
      stall_exp = (i == 5) || (i == 10);
      if (i == 5)       expect_wr(5'd11, 32'hAAAA_0001);
      else if (i == 10) expect_wr(5'd12, 32'hBBBB_0002);
      else              expect_wr(5'd20, 32'h100 + 32'(i));
      @(negedge clk);
      check_eq($sformatf("starve_stall_%0d", i), 32'(cpu_stall), 32'(stall_exp));
      if (i == 2) check_eq("starve_full", 32'(sl_ready), 32'd0);
      if (i == 6) check_eq("starve_one_left", 32'(sl_ready), 32'd1);
      tick();
    end
    idle();

    // Writes to r0 are suppressed; a suppressed head still retires.
    cpu_we = 1'b1; cpu_addr = 5'd0; cpu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("cpu_r0_we", 32'(rf_we), 32'd0);
    tick();
    idle();
    sl_valid = 1'b1; sl_addr = 5'd0; sl_data = 32'h55;
    tick();
    sl_valid = 1'b1; sl_addr = 5'd13; sl_data = 32'h1313;
    @(negedge clk);
    check_eq("sl_r0_we", 32'(rf_we), 32'd0);
    check_eq("sl_r0_ready", 32'(sl_ready), 32'd1);
    tick();
    idle();
    expect_wr(5'd13, 32'h1313);
    @(negedge clk);
    check_eq("after_r0_ready", 32'(sl_ready), 32'd1);
    tick();

    // Double issue to r9, then same-edge clear and set on r9.
    iss_valid = 1'b1; iss_addr = 5'd9; chk_addr1 = 5'd9; chk_addr2 = 5'd9;
    @(negedge clk);
    check_eq("iss9_first", 32'(iss_ready), 32'd1);
    tick();
    @(negedge clk);
    check_eq("iss9_second", 32'(iss_ready), 32'd0);
    check_eq("busy9_q1", 32'(chk_busy1), 32'd1);
    check_eq("busy9_q2", 32'(chk_busy2), 32'd1);
    tick();
    idle();
    sl_valid = 1'b1; sl_addr = 5'd9; sl_data = 32'h99;
    tick();
    idle();
    expect_wr(5'd9, 32'h99);
    tick();
    sl_valid = 1'b1; sl_addr = 5'd9; sl_data = 32'h98;
    @(negedge clk);
    check_eq("busy9_cleared", 32'(chk_busy1), 32'd0);
    tick();
    idle();
    expect_wr(5'd9, 32'h98);
    iss_valid = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    check_eq("iss9_reissue", 32'(iss_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    check_eq("busy9_set_wins", 32'(chk_busy2), 32'd1);
    tick();

    // Mid-cycle reset with a full FIFO and r3 pending.
    iss_valid = 1'b1; iss_addr = 5'd3; chk_addr1 = 5'd3;
    tick();
    idle();
    cpu_we = 1'b1; cpu_addr = 5'd21; cpu_data = 32'h2100;
    sl_valid = 1'b1; sl_addr = 5'd22; sl_data = 32'h2222;
    expect_wr(5'd21, 32'h2100);
    @(negedge clk);
    check_eq("busy3_set", 32'(chk_busy1), 32'd1);
    tick();
    cpu_data = 32'h2101; sl_addr = 5'd23; sl_data = 32'h2323;
    expect_wr(5'd21, 32'h2101);
    tick();
    sl_valid = 1'b0; cpu_data = 32'h2102;
    #1;
    check_eq("pre_rst_full", 32'(sl_ready), 32'd0);
    check_eq("pre_rst_we", 32'(rf_we), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_we", 32'(rf_we), 32'd0);
    check_eq("midrst_sl_ready", 32'(sl_ready), 32'd0);
    check_eq("midrst_busy3", 32'(chk_busy1), 32'd0);
    tick();
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_we", 32'(rf_we), 32'd0);
    check_eq("postrst_busy3", 32'(chk_busy1), 32'd0);
    check_eq("postrst_sl_ready", 32'(sl_ready), 32'd1);
    tick();
    @(negedge clk);
    check_eq("postrst_we2", 32'(rf_we), 32'd0);
    tick();

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
